// File: rtl/mem_io_responder.sv
// Byte-wide CPU bus responder: on-chip RAM plus the I/O window at 0x30000 (UART FIFOs, cycle
// counter, program stop). The RX FIFO is only built when MEMIO_RX_FIFO_EN is defined.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned FIFO_WIDTH     = 3,
    parameter int unsigned TX_FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sys_halt,
    output logic        tx_overflow
);
    localparam int unsigned Depth = 2 ** FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0]   CntDepth = (FIFO_WIDTH + 1)'(Depth);
    localparam logic [FIFO_WIDTH:0]   CntFull  = (FIFO_WIDTH + 1)'(Depth - TX_FULL_MARGIN);
    localparam logic [FIFO_WIDTH:0]   CntOne   = (FIFO_WIDTH + 1)'(1);
    localparam logic [FIFO_WIDTH-1:0] PtrOne   = FIFO_WIDTH'(1);

    logic [17:0]               addr;
    logic [13:0]               addr_unused;
    logic [2:0]                io_off;
    logic                      is_io;
    logic                      is_ram;
    logic                      rd_en;
    logic                      ram_we;
    logic                      ram_re;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;

    assign addr        = cpu_a[17:0];
    assign addr_unused = cpu_a[31:18];
    assign io_off      = addr[2:0];
    assign is_io       = (addr[17:16] == 2'b11);
    assign is_ram      = !is_io && ((32'(addr) >> RAM_ADDR_WIDTH) == 32'd0);
    assign rd_en       = rdy_in && !cpu_wr;
    assign ram_we      = rdy_in && cpu_wr && is_ram;
    assign ram_re      = rd_en && is_ram;
    assign ram_idx     = cpu_a[RAM_ADDR_WIDTH-1:0];

    // RAM is kept free of reset so it maps onto block memory
    logic [7:0] ram [2 ** RAM_ADDR_WIDTH];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= cpu_dout;
        end else if (ram_re) begin
            ram_q <= ram[ram_idx];
        end
    end

    logic        tx_push_req;
    logic [7:0]  tx_push_data;
    logic        halt_set;
    logic        rx_pop;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        snap_load;
    logic [7:0]  io_rdata;
    logic [31:0] cycle_q;
    logic [31:0] snap_q;
    logic        halt_q;

    always_comb begin
        tx_push_req  = 1'b0;
        tx_push_data = cpu_dout;
        halt_set     = 1'b0;
        rx_pop       = 1'b0;
        snap_load    = 1'b0;
        io_rdata     = 8'h00;
        if (rdy_in && is_io) begin
            if (cpu_wr) begin
                case (io_off)
                    3'd0: tx_push_req = (cpu_dout != 8'h00);
                    3'd4: begin
                        halt_set     = 1'b1;
                        tx_push_req  = 1'b1;
                        tx_push_data = 8'h00;
                    end
                    default: ;
                endcase
            end else begin
                case (io_off)
                    3'd0: begin
                        rx_pop   = !rx_empty;
                        io_rdata = rx_empty ? 8'h00 : rx_head;
                    end
                    3'd4: begin
                        snap_load = 1'b1;
                        io_rdata  = cycle_q[7:0];
                    end
                    3'd5: io_rdata = snap_q[15:8];
                    3'd6: io_rdata = snap_q[23:16];
                    3'd7: io_rdata = snap_q[31:24];
                    default: ;
                endcase
            end
        end
    end

    logic [7:0]            tx_mem [Depth];
    logic [FIFO_WIDTH-1:0] tx_wr_q;
    logic [FIFO_WIDTH-1:0] tx_rd_q;
    logic [FIFO_WIDTH:0]   tx_cnt_q;
    logic [FIFO_WIDTH:0]   tx_cnt_d;
    logic                  tx_pop;
    logic                  tx_push;
    logic                  full_q;
    logic                  ovf_q;

    assign tx_valid = (tx_cnt_q != '0);
    assign tx_pop   = tx_valid && tx_ready;
    // A full FIFO still takes the byte when the UART drains one on the same edge
    assign tx_push  = tx_push_req && ((tx_cnt_q < CntDepth) || tx_pop);
    assign tx_data  = tx_valid ? tx_mem[tx_rd_q] : 8'h00;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CntOne;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= tx_push_data;
        end
    end

    logic       din_ram_q;
    logic [7:0] io_din_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            halt_q    <= 1'b0;
            cycle_q   <= 32'd0;
            snap_q    <= 32'd0;
            din_ram_q <= 1'b0;
            io_din_q  <= 8'h00;
        end else begin
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + PtrOne;
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PtrOne;
            end
            tx_cnt_q <= tx_cnt_d;
            // Early full leaves room for CPU writes already in flight
            full_q   <= (tx_cnt_d >= CntFull);
            if (tx_push_req && !tx_push) begin
                ovf_q <= 1'b1;
            end
            if (halt_set) begin
                halt_q <= 1'b1;
            end
            if (!halt_q) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (snap_load) begin
                snap_q <= cycle_q;
            end
            if (rd_en) begin
                din_ram_q <= is_ram;
                if (!is_ram) begin
                    io_din_q <= io_rdata;
                end
            end
        end
    end

    assign cpu_din        = din_ram_q ? ram_q : io_din_q;
    assign io_buffer_full = full_q;
    assign sys_halt       = halt_q;
    assign tx_overflow    = ovf_q;

`ifdef MEMIO_RX_FIFO_EN
    logic [7:0]            rx_mem [Depth];
    logic [FIFO_WIDTH-1:0] rx_wr_q;
    logic [FIFO_WIDTH-1:0] rx_rd_q;
    logic [FIFO_WIDTH:0]   rx_cnt_q;
    logic                  rx_push;

    // A pop at full frees a slot, but ready stays low until the next cycle
    assign rx_ready = (rx_cnt_q < CntDepth);
    assign rx_push  = rx_valid && rx_ready;
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_head  = rx_mem[rx_rd_q];

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + PtrOne;
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PtrOne;
            end
            if (rx_push && !rx_pop) begin
                rx_cnt_q <= rx_cnt_q + CntOne;
            end else if (!rx_push && rx_pop) begin
                rx_cnt_q <= rx_cnt_q - CntOne;
            end
        end
    end
`else
    logic [9:0] rx_unused;

    assign rx_ready  = 1'b0;
    assign rx_empty  = 1'b1;
    assign rx_head   = 8'h00;
    assign rx_unused = {rx_pop, rx_valid, rx_data};
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sys_halt;
    logic        tx_overflow;

`ifdef MEMIO_RX_FIFO_EN
    localparam bit RxEn = 1'b1;
`else
    localparam bit RxEn = 1'b0;
`endif

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .cpu_a         (cpu_a),
        .cpu_wr        (cpu_wr),
        .cpu_dout      (cpu_dout),
        .cpu_din       (cpu_din),
        .io_buffer_full(io_buffer_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .sys_halt      (sys_halt),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: RAM as a sparse map, FIFOs as queues, counter as a plain tally of edges
    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] cnt_m;
    logic [31:0] snap_m;
    bit          halt_m;
    bit          ovf_m;
    bit          din_known;
    logic [7:0]  din_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        cnt_m     = 32'd0;
        snap_m    = 32'd0;
        halt_m    = 1'b0;
        ovf_m     = 1'b0;
        din_m     = 8'h00;
        din_known = 1'b1;
    endtask

    task automatic model_step();
        logic [17:0] a;
        logic [7:0]  pdat;
        bit          io;
        bit          ram;
        bit          tx_pop;
        bit          rx_rdy;
        bit          push_req;
        bit          set_halt;
        int          tx_n;
        a        = cpu_a[17:0];
        io       = (a[17:16] == 2'b11);
        ram      = !io && (a < 18'h20000);
        tx_n     = tx_q.size();
        tx_pop   = (tx_n > 0) && tx_ready;
        rx_rdy   = RxEn && (rx_q.size() < 8);
        push_req = 1'b0;
        set_halt = 1'b0;
        pdat     = 8'h00;
        if (rdy_in) begin
            if (cpu_wr) begin
                if (ram) begin
                    ram_m[int'(a)] = cpu_dout;
                end else if (io && a[2:0] == 3'd0 && cpu_dout != 8'h00) begin
                    push_req = 1'b1;
                    pdat     = cpu_dout;
                end else if (io && a[2:0] == 3'd4) begin
                    push_req = 1'b1;
                    set_halt = 1'b1;
                end
            end else begin
                din_known = 1'b1;
                if (ram) begin
                    if (ram_m.exists(int'(a))) din_m = ram_m[int'(a)];
                    else din_known = 1'b0;
                end else if (!io) begin
                    din_m = 8'h00;
                end else begin
                    case (a[2:0])
                        3'd0: begin
                            if (rx_q.size() > 0) din_m = rx_q.pop_front();
                            else din_m = 8'h00;
                        end
                        3'd4: begin
                            snap_m = cnt_m;
                            din_m  = cnt_m[7:0];
                        end
                        3'd5: din_m = snap_m[15:8];
                        3'd6: din_m = snap_m[23:16];
                        3'd7: din_m = snap_m[31:24];
                        default: din_m = 8'h00;
                    endcase
                end
            end
        end
        if (tx_pop) void'(tx_q.pop_front());
        if (push_req) begin
            if (tx_n < 8 || tx_pop) tx_q.push_back(pdat);
            else ovf_m = 1'b1;
        end
        if (rx_rdy && rx_valid) rx_q.push_back(rx_data);
        if (!halt_m) cnt_m = cnt_m + 32'd1;
        if (set_halt) halt_m = 1'b1;
    endtask

    task automatic check_model();
        if (din_known) chk("din_model", cpu_din, din_m);
        chk("tx_valid_model", tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) chk("tx_data_model", tx_data, tx_q[0]);
        chk("full_model", io_buffer_full, tx_q.size() >= 6);
        chk("rx_ready_model", rx_ready, RxEn && (rx_q.size() < 8));
        chk("halt_model", sys_halt, halt_m);
        chk("ovf_model", tx_overflow, ovf_m);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in   = rdy;
        cpu_wr   = wr;
        cpu_a    = a;
        cpu_dout = d;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    typedef struct {
        bit          rdy;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  dout;
        logic [7:0]  exp_din;
        bit          exp_tx_valid;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] snap_val;
    int          guard;
    int          cat;
    bit          w;
    logic [31:0] a;
    logic [31:0] hi;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0001_1234 & 32'h0000_1234, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_1234, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0002_5000, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0002_5000, 8'h77, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0002_5000, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0001_FFFF, 8'h3C, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 8'h3C, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_1234, 8'h00, 8'h3C, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0003_0002, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'hABC0_1234, 8'h00, 8'hA5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0003_0001, 8'h55, 8'hA5, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h0003_0000, 8'h00, 8'hA5, 1'b0};

        // Reset values
        do_reset();
        chk("rst_cpu_din", cpu_din, 8'h00);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, RxEn);
        chk("rst_halt", sys_halt, 1'b0);
        chk("rst_ovf", tx_overflow, 1'b0);

        // Vector table: RAM, unmapped, plain I/O decode
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].dout);
            tick();
            chk($sformatf("vec%0d_din", i), cpu_din, vecs[i].exp_din);
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].exp_tx_valid);
            check_model();
        end

        // Cycle counter: idle 5 cycles, then byte reads of the snapshot
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        snap_val = 32'd0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0003_0004 + i, 8'h00);
            tick();
            snap_val[i*8 +: 8] = cpu_din;
        end
        chk("cnt_snapshot_5", snap_val, 32'd5);
        // Snapshot taken at 0xFF must not tear into byte 1 on the later reads
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        guard = 0;
        while (cnt_m != 32'hFF && guard < 1000) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0003_0004 + i, 8'h00);
            tick();
            snap_val[i*8 +: 8] = cpu_din;
            check_model();
        end
        chk("cnt_snapshot_ff", snap_val, 32'h0000_00FF);

        // TX early full, zero drop, overflow, push-with-pop at full
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'h41);
            tick();
            if (i == 1) begin
                chk("tx_valid_first", tx_valid, 1'b1);
                chk("tx_data_first", tx_data, 8'h41);
            end
            chk($sformatf("tx_full_after_%0d", i), io_buffer_full, i >= 6);
        end
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h00);
        tick();
        chk("tx_full_after_zero", io_buffer_full, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'h41);
            tick();
        end
        chk("tx_ovf_at_8", tx_overflow, 1'b0);
        tick();
        chk("tx_ovf_after_9", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h42);
        tick();
        chk("tx_full_push_pop", io_buffer_full, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_drain%0d_valid", i), tx_valid, 1'b1);
            chk($sformatf("tx_drain%0d_data", i), tx_data, (i < 7) ? 8'h41 : 8'h42);
            tick();
        end
        chk("tx_drained", tx_valid, 1'b0);
        check_model();

        // RX pushes then three reads
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        tick();
        rx_data  = 8'h32;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0003_0000, 8'h00);
            tick();
            chk($sformatf("rx_read%0d", i), cpu_din,
                RxEn ? ((i == 0) ? 8'h31 : (i == 1) ? 8'h32 : 8'h00) : 8'h00);
        end
        chk("rx_ready_after", rx_ready, RxEn);

        // Program stop: halt, 0x00 into TX, frozen counter
        do_reset();
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h99);
        tick();
        chk("halt_set", sys_halt, 1'b1);
        chk("halt_tx_valid", tx_valid, 1'b1);
        chk("halt_tx_data", tx_data, 8'h00);
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("halt_cnt_frozen", cpu_din, 8'h01);
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 20; i++) tick();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("halt_cnt_frozen_later", cpu_din, 8'h01);

        // Asynchronous reset between edges
        rst_in = 1'b1;
        #1;
        chk("async_rst_halt", sys_halt, 1'b0);
        chk("async_rst_tx_valid", tx_valid, 1'b0);
        chk("async_rst_din", cpu_din, 8'h00);
        do_reset();

        // Randomized run against the reference model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int i = 0; i < 800; i++) begin
                cat = $urandom_range(0, 9);
                w   = 1'($urandom_range(0, 1));
                hi  = $urandom & 32'hFFFC_0000;
                if (cat < 2) begin
                    a = 32'($urandom_range(0, 15));
                end else if (cat < 4) begin
                    a = 32'h1FFF0 + 32'($urandom_range(0, 15));
                end else if (cat == 4) begin
                    a = 32'h20000 + 32'($urandom_range(0, 16'hFFFF));
                end else begin
                    a = 32'h30000 | (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
                    if (w && a[2:0] == 3'd4 && $urandom_range(0, 49) != 0) a[2:0] = 3'd0;
                end
                rdy_in   = ($urandom_range(0, 7) != 0);
                cpu_wr   = w;
                cpu_a    = hi | a;
                cpu_dout = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                tx_ready = ($urandom_range(0, 2) == 0);
                rx_valid = ($urandom_range(0, 2) == 0);
                rx_data  = 8'($urandom);
                tick();
                check_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
